rle_decoder: RTL
================

# rle_decoder

Streaming run-length decoder that sits directly downstream of the `rle` compressor. It consumes 16-bit `{count[15:8], value[7:0]}` pairs, exactly the word layout that `rle` presents on `read_data_b`. It expands each pair into `count` repetitions of `value` on a byte-wide valid/ready output stream. Round-trip benches use it to check compressor output against the original data.

## Interface
- `MAX_FRAME_W`, default 16: width of the emitted-byte counter `out_total`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: pair present on `in_pair`.
- `in_ready` out 1: decoder accepts the pair this cycle.
- `in_pair` in 16: `[15:8]` run count (unsigned, 0–255), `[7:0]` value.
- `in_last` in 1: pair is the final pair of a frame.
- `out_valid` out 1: byte present on `out_data`.
- `out_ready` in 1: downstream accepts the byte.
- `out_data` out 8: decoded byte.
- `out_last` out 1: byte is the final byte of the frame.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `out_total` out MAX_FRAME_W: bytes emitted in the current frame, including the byte being accepted.
- `cnt_err` out 1: sticky flag, set when a zero-count pair is received (see Configuration).

## Operation
- Handshake rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
  - `out_valid`, `out_data`, and `out_last` stay stable while `out_valid && !out_ready`.
- State machine, two states:
  - `IDLE`: no pair held. `in_ready`=1 and `out_valid`=0.
  - `EXPAND`: pair held. `out_valid`=1 and `out_data`=held value.
- Registers: 8-bit `remaining` counter, held value, held last flag.
- `IDLE` → `EXPAND` when a pair with count ≥ 1 is accepted. Load `remaining`=count.
- In `EXPAND`, each output transfer decrements `remaining`.
- When `remaining`==1 and an output transfer occurs:
  - If `in_valid` with count ≥ 1: load the new pair and stay in `EXPAND` (back-to-back, no bubble).
  - Otherwise: go to `IDLE`.
- `in_ready` = (`IDLE`) or (`EXPAND` and `remaining`==1 and `out_ready`). This is a combinational path from `out_ready`.
- `out_last` = held last flag and `remaining`==1.
- Zero-count pair:
  - It is accepted (consumed) and produces no output byte.
  - The state does not change.
  - If it also carries `in_last`, `frame_done` pulses the following cycle and `out_total` clears.
- Frame accounting:
  - `out_total` increments on each output transfer.
  - `out_total` clears to 0 on the cycle after the transfer of a byte with `out_last`=1.
  - `out_total` wraps modulo 2^MAX_FRAME_W with no error.
- `frame_done` pulses for one cycle on the cycle after the final transfer.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - State `IDLE`; `remaining`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `frame_done`=0, `out_total`=0, `cnt_err`=0.
  - `in_ready`=1 from the first cycle after reset release.
- Latency: a pair accepted at edge N presents its first byte with `out_valid`=1 after edge N.
- Throughput: one byte per cycle while `out_ready`=1, including across pair boundaries.
- Run duration: a pair with count C occupies exactly C output transfers. No idle cycles are inserted.
- Reset mid-run: the held pair and remaining count are discarded, the partial frame is not completed, and no `frame_done` pulse is issued.
- Back-pressure: if `out_ready`=0 while `remaining`==1, `in_ready`=0 and the next pair waits.
- Count 255: expands to 255 bytes. The counter never underflows because a zero count never enters `EXPAND`.

## Configuration
- `RLE_DEC_CNT_ERR_EN`:
  - Defined: a zero-count pair sets `cnt_err` to 1. It stays set until reset. Decoding continues normally.
  - Undefined: `cnt_err` is tied to 0 and zero-count pairs are dropped silently.
  - In both cases the datapath behaviour is identical.

## Test plan
- Reset, then pairs (3,5), (2,7), (1,9) with `in_last` on the final pair and `out_ready`=1:
  - Output 5,5,5,7,7,9 on six consecutive cycles.
  - `out_last` set only on the 9.
  - `frame_done` pulses once.
  - `out_total` reaches 6, then clears.
- Hex frame (2,0xA), (3,0xF), (1,0x1) with `out_ready` toggling 1/0 every cycle:
  - Same byte sequence A,A,F,F,F,1.
  - Outputs held stable during stalls.
  - `in_ready` low during stalls at `remaining`==1.
- Pair (0,0x33) between (2,0x11) and (1,0x22):
  - Output 11,11,22.
  - `cnt_err`=1 with the macro defined, 0 without.
- Pair (255,0xAB):
  - Exactly 255 bytes of AB.
  - The next pair is accepted in the same cycle as the 255th transfer.
- Assert `rst_n`=0 after 2 bytes of a (4,0x55) run:
  - All outputs return to reset values the next cycle.
  - A new (1,0x66) `in_last` pair yields a single 66 with `out_last`, and `out_total`=1.

Source files
------------

// File: rtl/rle_decoder.sv
// rle_decoder: expands 16-bit {count, value} run-length pairs into a byte
// stream over valid/ready handshakes. A pair is held in a two-state machine
// (IDLE / EXPAND) and its value is emitted count times. When the last byte of
// a run is accepted, the next pair can be loaded in the same cycle, so runs
// follow each other without gaps.
// Optional feature: define RLE_DEC_CNT_ERR_EN to make cnt_err a sticky flag
// that is set by zero-count pairs. Without it, cnt_err is tied to 0.
module rle_decoder #(
  parameter int MAX_FRAME_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_pair,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic                   frame_done,
  output logic [MAX_FRAME_W-1:0] out_total,
  output logic                   cnt_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t                 state;
  logic [7:0]             remaining;
  logic                   last_q;
  logic [MAX_FRAME_W-1:0] total_q;

  logic in_xfer;
  logic out_xfer;
  logic zero_cnt;
  logic run_end;

  assign zero_cnt  = (in_pair[15:8] == 8'd0);
  assign run_end   = (remaining == 8'd1);
  assign out_valid = (state == EXPAND);
  assign out_last  = last_q && run_end;
  // A new pair may enter only when nothing is held, or when the last byte of
  // the held run leaves this very cycle (gapless hand-over between runs).
  assign in_ready  = (state == IDLE) || (run_end && out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // NOTE: out_total is the registered count plus the byte being transferred
  // now, so the final byte of a frame is counted while it is on the bus.
  assign out_total = total_q + MAX_FRAME_W'(out_xfer);

  // FSM, run counter, held pair and frame accounting.
  always_ff @(posedge clk) begin
    // NOTE: every assignment in this block is non-blocking. All right-hand
    // sides see the values from before the clock edge, and the last write
    // to a signal wins.
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      out_data   <= 8'd0;
      last_q     <= 1'b0;
      total_q    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (out_xfer) begin
        total_q <= total_q + 1'b1;
      end
      // A frame ends on its last byte, or on a zero-count pair marked last.
      if ((out_xfer && out_last) || (in_xfer && zero_cnt && in_last)) begin
        total_q    <= '0;
        frame_done <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          // Zero-count pairs are consumed here and leave the state unchanged.
          if (in_xfer && !zero_cnt) begin
            state     <= EXPAND;
            remaining <= in_pair[15:8];
            out_data  <= in_pair[7:0];
            last_q    <= in_last;
          end
        end
        EXPAND: begin
          if (out_xfer) begin
            if (run_end) begin
              if (in_xfer && !zero_cnt) begin
                remaining <= in_pair[15:8];
                out_data  <= in_pair[7:0];
                last_q    <= in_last;
              end else begin
                state     <= IDLE;
                remaining <= 8'd0;
                last_q    <= 1'b0;
              end
            end else begin
              remaining <= remaining - 8'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef RLE_DEC_CNT_ERR_EN
  // Sticky flag: stays set after any zero-count pair until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_err <= 1'b0;
    end else if (in_xfer && zero_cnt) begin
      cnt_err <= 1'b1;
    end
  end
`else
  assign cnt_err = 1'b0;
`endif

endmodule
